coeff_bank_server: RTL

- Double-buffered coefficient memory that serves the filter bank's coefficient read port.
- Accepts the filter bank's coeffaddress and returns 36-bit packed coefficient words coeff0..coeff7, one per filter.
- A host streams 18-bit coefficients into the shadow bank through a valid/ready handshake.
- The shadow bank becomes active only on a din_enable sample boundary, so a filter never computes with a mix of old and new coefficients.

---
 rtl/coeff_bank_server_if.sv | 12 +
 rtl/coeff_bank_server.sv | 136 +++++++++++++
 2 files changed

// File: rtl/coeff_bank_server_if.sv
// Host-side coefficient load channel: start pulse plus valid/ready stream of CW-bit taps.
interface coeff_bank_server_if #(
   parameter int CW = 18
) ();
   logic          load_start;
   logic [CW-1:0] load_data;
   logic          load_valid;
   logic          load_ready;

   modport master (output load_start, load_data, load_valid, input load_ready);
   modport slave  (input load_start, load_data, load_valid, output load_ready);
endinterface

// File: rtl/coeff_bank_server.sv
// Double-buffered coefficient store for an 8-filter bank; the shadow bank is
// filled by the host and swapped in only on a din_enable sample boundary.
module coeff_bank_server #(
   parameter int TAPS = 128,
   parameter int CW   = 18,
   parameter int AW   = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  din_enable,
   input  logic [AW-1:0]         coeffaddress,
   output logic [2*CW-1:0]       coeff0,
   output logic [2*CW-1:0]       coeff1,
   output logic [2*CW-1:0]       coeff2,
   output logic [2*CW-1:0]       coeff3,
   output logic [2*CW-1:0]       coeff4,
   output logic [2*CW-1:0]       coeff5,
   output logic [2*CW-1:0]       coeff6,
   output logic [2*CW-1:0]       coeff7,
   coeff_bank_server_if.slave    ld,
   output logic                  busy,
   output logic                  swap_done,
   output logic                  active_bank,
   output logic                  load_err
);
   localparam int TW = $clog2(TAPS);
   localparam int WORDS = TAPS / 2;

   typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

   state_t          state_q, state_d;
   logic [2:0]      fidx_q, fidx_d;
   logic [TW-1:0]   tidx_q, tidx_d;
   logic [CW-1:0]   lo_q, lo_d;
   logic            active_q, active_d;
   logic            swap_q, swap_d;
   logic            err_q, err_d;
   logic            ready_q, ready_d;
   logic            we;
   logic [2*CW-1:0] coeff_q [8];

   // Not reset: contents are only meaningful after a completed load is committed.
   logic [2*CW-1:0] mem [2][8][WORDS];

   always_comb begin
      state_d  = state_q;
      fidx_d   = fidx_q;
      tidx_d   = tidx_q;
      lo_d     = lo_q;
      active_d = active_q;
      swap_d   = 1'b0;
      err_d    = err_q;
      we       = 1'b0;

      if (ld.load_valid && state_q != LOAD)
         err_d = 1'b1;

      // A restart wins over a same-cycle transfer or commit.
      if (ld.load_start) begin
         state_d = LOAD;
         fidx_d  = '0;
         tidx_d  = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            LOAD: begin
               if (ld.load_valid && ready_q) begin
                  if (!tidx_q[0]) lo_d = ld.load_data;
                  else            we   = 1'b1;
                  tidx_d = tidx_q + 1'b1;
                  if (tidx_q == TW'(TAPS - 1)) begin
                     tidx_d = '0;
                     fidx_d = fidx_q + 3'd1;
                     if (fidx_q == 3'd7) state_d = PEND;
                  end
               end
            end
            PEND: begin
               if (din_enable) begin
                  active_d = ~active_q;
                  swap_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ready_d = (state_d == LOAD);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         fidx_q   <= '0;
         tidx_q   <= '0;
         lo_q     <= '0;
         active_q <= 1'b0;
         swap_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         for (int n = 0; n < 8; n++) coeff_q[n] <= '0;
      end else begin
         state_q  <= state_d;
         fidx_q   <= fidx_d;
         tidx_q   <= tidx_d;
         lo_q     <= lo_d;
         active_q <= active_d;
         swap_q   <= swap_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         for (int n = 0; n < 8; n++) coeff_q[n] <= mem[active_q][n][coeffaddress];
      end
   end

   always_ff @(posedge clock) begin
      if (reset && we)
         mem[~active_q][fidx_q][tidx_q[TW-1:1]] <= {ld.load_data, lo_q};
   end

   assign ld.load_ready = ready_q;
   assign busy          = (state_q != IDLE);
   assign swap_done     = swap_q;
   assign active_bank   = active_q;
   assign load_err      = err_q;

   assign coeff0 = coeff_q[0];
   assign coeff1 = coeff_q[1];
   assign coeff2 = coeff_q[2];
   assign coeff3 = coeff_q[3];
   assign coeff4 = coeff_q[4];
   assign coeff5 = coeff_q[5];
   assign coeff6 = coeff_q[6];
   assign coeff7 = coeff_q[7];
endmodule
